// File: rtl/keypad_emulator.sv
// Switch end of a 4x4 row-scan / column-sense keypad: accepts press requests
// over valid/ready, closes one contact with make/break bounce, drives col from row.
module keypad_emulator #(
    parameter int BOUNCE_CYCLES  = 8,
    parameter int BOUNCE_TOGGLES = 3,
    parameter int HOLD_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        row,
    output logic [3:0]        col,
    input  logic [3:0]        key_pos,
    input  logic [HOLD_W-1:0] hold_cycles,
    input  logic              press_valid,
    output logic              press_ready,
    output logic              pressed,
    output logic              press_done
);
    localparam int PW = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
    localparam int TW = (BOUNCE_TOGGLES > 1) ? $clog2(BOUNCE_TOGGLES) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(BOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] PAIR_LAST  = TW'((BOUNCE_TOGGLES > 0) ? BOUNCE_TOGGLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, MAKE, HOLD, BREAK} state_t;

    state_t            state_reg, state_next;
    logic [PW-1:0]     phase_reg, phase_next;
    logic [TW-1:0]     pair_reg, pair_next;
    logic              half_reg, half_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic [3:0]        key_reg, key_next;
    logic              contact_reg, contact_next;
    logic              done_reg, done_next;

    logic              accept;
    logic              phase_end;
    logic [HOLD_W-1:0] hold_eff;

    assign press_ready = (state_reg == IDLE) && !reset;
    assign accept      = press_valid && press_ready;
    assign phase_end   = (phase_reg == PHASE_LAST);
    assign hold_eff    = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            phase_reg   <= '0;
            pair_reg    <= '0;
            half_reg    <= 1'b0;
            hold_reg    <= '0;
            key_reg     <= '0;
            contact_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            phase_reg   <= phase_next;
            pair_reg    <= pair_next;
            half_reg    <= half_next;
            hold_reg    <= hold_next;
            key_reg     <= key_next;
            contact_reg <= contact_next;
            done_reg    <= done_next;
        end
    end

    // half_reg selects the first or second phase of a bounce pair:
    // MAKE pairs are (closed, open), BREAK pairs are (open, closed).
    always_comb begin
        state_next   = state_reg;
        phase_next   = phase_reg;
        pair_next    = pair_reg;
        half_next    = half_reg;
        hold_next    = hold_reg;
        key_next     = key_reg;
        contact_next = contact_reg;
        done_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    key_next     = key_pos;
                    hold_next    = hold_eff;
                    contact_next = 1'b1;
                    phase_next   = '0;
                    half_next    = 1'b0;
                    pair_next    = '0;
                    state_next   = (BOUNCE_TOGGLES == 0) ? HOLD : MAKE;
                end
            end
            MAKE: begin
                if (phase_end) begin
                    phase_next = '0;
                    if (!half_reg) begin
                        half_next    = 1'b1;
                        contact_next = 1'b0;
                    end else begin
                        half_next    = 1'b0;
                        contact_next = 1'b1;
                        if (pair_reg == PAIR_LAST) begin
                            state_next = HOLD;
                        end else begin
                            pair_next = pair_reg + TW'(1);
                        end
                    end
                end else begin
                    phase_next = phase_reg + PW'(1);
                end
            end
            HOLD: begin
                if (hold_reg == HOLD_W'(1)) begin
                    contact_next = 1'b0;
                    phase_next   = '0;
                    half_next    = 1'b0;
                    pair_next    = '0;
                    if (BOUNCE_TOGGLES == 0) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = BREAK;
                    end
                end else begin
                    hold_next = hold_reg - HOLD_W'(1);
                end
            end
            BREAK: begin
                if (phase_end) begin
                    phase_next = '0;
                    if (!half_reg) begin
                        half_next    = 1'b1;
                        contact_next = 1'b1;
                    end else begin
                        half_next    = 1'b0;
                        contact_next = 1'b0;
                        if (pair_reg == PAIR_LAST) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end else begin
                            pair_next = pair_reg + TW'(1);
                        end
                    end
                end else begin
                    phase_next = phase_reg + PW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Column sense is purely combinational, like a physical switch.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            assign col[gi] = !(contact_reg && (key_reg[1:0] == 2'(gi)) && !row[key_reg[3:2]]);
        end
    endgenerate

    assign pressed    = contact_reg;
    assign press_done = done_reg;

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: two instances (bouncy and clean edges)
// compared cycle by cycle against a timeline model of the press sequence.
module tb_keypad_emulator;
    localparam int A_B = 2;
    localparam int A_T = 2;
    localparam int B_B = 8;
    localparam int B_T = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row;
    logic [3:0]  key_pos;
    logic [15:0] hold_cycles;
    logic        valid_a, valid_b;
    logic [3:0]  col_a, col_b;
    logic        ready_a, ready_b, pressed_a, pressed_b, done_a, done_b;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    keypad_emulator #(.BOUNCE_CYCLES(A_B), .BOUNCE_TOGGLES(A_T), .HOLD_W(16)) dut_a (
        .clk(clk), .reset(reset), .row(row), .col(col_a), .key_pos(key_pos),
        .hold_cycles(hold_cycles), .press_valid(valid_a), .press_ready(ready_a),
        .pressed(pressed_a), .press_done(done_a)
    );

    keypad_emulator #(.BOUNCE_CYCLES(B_B), .BOUNCE_TOGGLES(B_T), .HOLD_W(16)) dut_b (
        .clk(clk), .reset(reset), .row(row), .col(col_b), .key_pos(key_pos),
        .hold_cycles(hold_cycles), .press_valid(valid_b), .press_ready(ready_b),
        .pressed(pressed_b), .press_done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected contact level at cycle i after acceptance, from the press timeline.
    function automatic logic model_contact(input int i, input int b, input int t, input int h);
        int mk;
        mk = 2 * t * b;
        if (i < mk)              return ((i % (2 * b)) < b);
        if (i < mk + h)          return 1'b1;
        if (i < mk + h + mk)     return (((i - mk - h) % (2 * b)) >= b);
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_col(input logic c, input logic [3:0] k, input logic [3:0] r);
        logic [3:0] v;
        v = 4'hF;
        if (c && !r[k[3:2]]) v[k[1:0]] = 1'b0;
        return v;
    endfunction

    // Starts at a negedge with the selected DUT idle; ends at the negedge of
    // the press_done cycle. mode: 0 random rows, 1 fixed row, 2 one-cold scan.
    task automatic run_press(input int sel, input logic [3:0] key, input int hold,
                             input int mode, input logic [3:0] frow, input bit keep,
                             input logic [3:0] nkey, input int nhold);
        int b, t, h, n;
        logic ep;
        b = sel ? B_B : A_B;
        t = sel ? B_T : A_T;
        h = (hold == 0) ? 1 : hold;
        n = 4 * t * b + h + 1;
        key_pos     = key;
        hold_cycles = 16'(hold);
        if (sel) valid_b = 1'b1; else valid_a = 1'b1;
        #1 check("ready_at_request", sel ? ready_b : ready_a, 1'b1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!keep) begin
                valid_a = 1'b0;
                valid_b = 1'b0;
            end else if (i == 1) begin
                key_pos     = nkey;
                hold_cycles = 16'(nhold);
            end
            case (mode)
                1:       row = frow;
                2:       row = ~(4'(1) << (i % 4));
                default: row = 4'($urandom);
            endcase
            #1;
            ep = model_contact(i, b, t, h);
            check("pressed", sel ? pressed_b : pressed_a, ep);
            check("col", sel ? col_b : col_a, model_col(ep, key, row));
            check("press_done", sel ? done_b : done_a, (i == n - 1));
            check("press_ready", sel ? ready_b : ready_a, (i == n - 1));
        end
        $display("[TB] press dut=%0d key=%b hold=%0d mode=%0d cycles=%0d", sel, key, hold, mode, n);
    endtask

    initial begin
        reset = 1'b1; row = 4'h0; key_pos = 4'h0; hold_cycles = 16'd0;
        valid_a = 1'b0; valid_b = 1'b0;

        // Reset with all rows low
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_col_a", col_a, 4'hF);
            check("rst_col_b", col_b, 4'hF);
            check("rst_pressed_a", pressed_a, 1'b0);
            check("rst_ready_a", ready_a, 1'b0);
            check("rst_ready_b", ready_b, 1'b0);
        end
        reset = 1'b0;
        #1 check("post_rst_ready_a", ready_a, 1'b1);
        check("post_rst_ready_b", ready_b, 1'b1);
        $display("[TB] reset checks done");
        @(negedge clk);

        // Clean press on the scanned row and on a different row
        run_press(1, 4'b0110, 5, 1, 4'b1101, 1'b0, 4'h0, 0);
        run_press(1, 4'b0110, 5, 1, 4'b1110, 1'b0, 4'h0, 0);

        // Bounce sequence
        run_press(0, 4'b0110, 4, 1, 4'b1101, 1'b0, 4'h0, 0);
        run_press(0, 4'b1011, 4, 0, 4'h0, 1'b0, 4'h0, 0);

        // Held press_valid with mid-press key change
        run_press(0, 4'b0101, 3, 0, 4'h0, 1'b1, 4'b1010, 2);
        run_press(0, 4'b1010, 2, 0, 4'h0, 1'b0, 4'h0, 0);
        run_press(1, 4'b0011, 2, 0, 4'h0, 1'b1, 4'b1100, 3);
        run_press(1, 4'b1100, 3, 0, 4'h0, 1'b0, 4'h0, 0);

        // hold_cycles == 0 behaves as 1
        run_press(0, 4'b0000, 0, 0, 4'h0, 1'b0, 4'h0, 0);
        run_press(1, 4'b1111, 0, 0, 4'h0, 1'b0, 4'h0, 0);

        // Row scan sweep on key 4'b1111
        run_press(1, 4'b1111, 12, 2, 4'h0, 1'b0, 4'h0, 0);
        run_press(0, 4'b1111, 6, 2, 4'h0, 1'b0, 4'h0, 0);

        // Random presses
        for (int r = 0; r < 8; r++) begin
            run_press(int'($urandom_range(0, 1)), 4'($urandom), int'($urandom_range(0, 7)),
                      0, 4'h0, 1'b0, 4'h0, 0);
        end

        // Abort during HOLD
        key_pos = 4'b1001; hold_cycles = 16'd10; row = 4'h0; valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        repeat (4 * A_B * A_T / 2 + 2) @(negedge clk);
        #1 check("abort_in_hold", pressed_a, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_pressed", pressed_a, 1'b0);
        check("abort_col", col_a, 4'hF);
        check("abort_done", done_a, 1'b0);
        check("abort_ready_in_reset", ready_a, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("abort_no_done", done_a, 1'b0);
        end
        check("abort_ready_after", ready_a, 1'b1);
        $display("[TB] abort checks done");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
